// File: rtl/chan_tx_sched_pkg.sv
// rtl/chan_tx_sched_pkg.sv - shared types, defaults and header packing for chan_tx_sched
package chan_tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam logic [7:0] HDR_MAGIC_DEF = 8'hA5;
    localparam int         IFG_DEF       = 12;
    localparam int         SEQ_W         = 16;

    // Header layout, MSB first: tag(8) | 4'h0 | id(4) | len(8) | seq(16) | 24'h0
    function automatic logic [63:0] make_hdr(input logic [7:0]  magic,
                                             input logic [3:0]  id,
                                             input logic [7:0]  len,
                                             input logic [15:0] seq);
        return {magic, 4'h0, id, len, seq, 24'h0};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker, first eligible bit strictly after ptr
//
// Ports:
//   req   : request vector
//   mask  : eligibility vector, ANDed with req
//   ptr   : index of the previous winner; search starts at ptr+1 and wraps
//   grant : one-hot winner (all zero when nothing eligible)
//   id    : binary index of the winner
//   any   : at least one eligible request
module rr_arbiter #(
    parameter int N   = 16,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   mask,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] id,
    output logic           any
);

    logic [N-1:0]   elig;
    logic           found;
    logic [IDW-1:0] idx;

    assign elig = req & mask;
    assign any  = |elig;

    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        idx   = '0;
        // Offsets 1..N visit ptr+1 first and ptr itself last, so the
        // previous winner has the lowest priority.
        for (int k = 1; k <= N; k++) begin
            idx = IDW'((int'(ptr) + k) % N);
            if (!found && elig[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                id         = idx;
            end
        end
    end

endmodule

// File: rtl/chan_tx_sched.sv
// rtl/chan_tx_sched.sv - round-robin scheduler framing channel FIFO bursts onto one TX stream
//
// Ports:
//   fifo_clk, rst            : clock, synchronous active-high reset
//   en                       : scheduler enable, only looked at when idle
//   ch_mask, ch_req, ch_len  : per-channel eligibility, burst-ready flag, burst length
//   ch_data                  : per-channel FWFT head word
//   ch_rd                    : one-hot pop strobe to the granted FIFO
//   ch_grant                 : one-hot grant, header through last data beat
//   tx_data/valid/sop/eop    : framed output stream, tx_ready is the sink handshake
//   busy                     : not idle
//   frame_seq                : sequence number the next frame will carry
module chan_tx_sched
    import chan_tx_sched_pkg::*;
#(
    parameter int         NCH       = 16,
    parameter int         DW        = 64,
    parameter int         LW        = 8,
    parameter int         IFG_CYC   = IFG_DEF,
    parameter logic [7:0] HDR_MAGIC = HDR_MAGIC_DEF
) (
    input  logic                fifo_clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NCH-1:0]      ch_mask,
    input  logic [NCH-1:0]      ch_req,
    input  logic [NCH*LW-1:0]   ch_len,
    input  logic [NCH*DW-1:0]   ch_data,
    output logic [NCH-1:0]      ch_rd,
    output logic [NCH-1:0]      ch_grant,
    output logic [DW-1:0]       tx_data,
    output logic                tx_valid,
    output logic                tx_sop,
    output logic                tx_eop,
    input  logic                tx_ready,
    output logic                busy,
    output logic [SEQ_W-1:0]    frame_seq
);

    localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int GW  = $clog2(IFG_CYC + 1);

    state_t         state, next_state;
    logic [IDW-1:0] rr_ptr;
    logic [NCH-1:0] arb_grant;
    logic [IDW-1:0] arb_id;
    logic           arb_any;
    logic           start;

    logic [NCH-1:0] gnt_oh;
    logic [IDW-1:0] gnt_id;
    logic [LW-1:0]  gnt_len;
    logic [LW-1:0]  wcnt;
    logic [GW-1:0]  gap_cnt;
    logic           last_word;

    logic [DW-1:0]  data_arr [NCH];
    logic [LW-1:0]  len_arr  [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_unpack
        assign data_arr[g] = ch_data[g*DW +: DW];
        assign len_arr[g]  = ch_len[g*LW +: LW];
    end

    rr_arbiter #(.N(NCH), .IDW(IDW)) u_arb (
        .req   (ch_req),
        .mask  (ch_mask),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .id    (arb_id),
        .any   (arb_any)
    );

    assign start     = (state == ST_IDLE) && en && arb_any;
    assign last_word = (wcnt == gnt_len - LW'(1));

    always_comb begin
        next_state = state;
        tx_valid   = 1'b0;
        tx_sop     = 1'b0;
        tx_eop     = 1'b0;
        tx_data    = '0;
        ch_rd      = '0;
        ch_grant   = '0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (start) next_state = ST_HDR;
            end
            ST_HDR: begin
                tx_valid = 1'b1;
                tx_sop   = 1'b1;
                tx_eop   = (gnt_len == '0);
                tx_data  = DW'(make_hdr(HDR_MAGIC, 4'(gnt_id), 8'(gnt_len), frame_seq));
                ch_grant = gnt_oh;
                if (tx_ready) next_state = (gnt_len == '0) ? ST_GAP : ST_DATA;
            end
            ST_DATA: begin
                tx_valid = 1'b1;
                tx_eop   = last_word;
                tx_data  = data_arr[gnt_id];
                ch_grant = gnt_oh;
                // Pop only on a real accept so the FWFT head stays put under backpressure.
                if (tx_ready) begin
                    ch_rd = gnt_oh;
                    if (last_word) next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GW'(IFG_CYC - 1)) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge fifo_clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= IDW'(NCH - 1);
            gnt_oh    <= '0;
            gnt_id    <= '0;
            gnt_len   <= '0;
            wcnt      <= '0;
            gap_cnt   <= '0;
            frame_seq <= '0;
        end else begin
            state <= next_state;
            case (state)
                ST_IDLE: begin
                    gap_cnt <= '0;
                    if (start) begin
                        gnt_oh  <= arb_grant;
                        gnt_id  <= arb_id;
                        gnt_len <= len_arr[arb_id];
                        rr_ptr  <= arb_id;
                        wcnt    <= '0;
                    end
                end
                ST_HDR: begin
                    if (tx_ready) frame_seq <= frame_seq + 16'd1;
                end
                ST_DATA: begin
                    if (tx_ready) wcnt <= wcnt + LW'(1);
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt + GW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chan_tx_sched.sv
// tb/tb_chan_tx_sched.sv - self-checking bench for chan_tx_sched
module tb_chan_tx_sched;

    localparam int NCH = 16;
    localparam int DW  = 64;
    localparam int LW  = 8;
    localparam int IFG = 12;

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [15:0] grant;
        int          cyc;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [NCH-1:0]    ch_mask;
    logic [NCH-1:0]    ch_req;
    logic [NCH*LW-1:0] ch_len;
    logic [NCH*DW-1:0] ch_data;
    logic [NCH-1:0]    ch_rd;
    logic [NCH-1:0]    ch_grant;
    logic [DW-1:0]     tx_data;
    logic              tx_valid;
    logic              tx_sop;
    logic              tx_eop;
    logic              tx_ready;
    logic              busy;
    logic [15:0]       frame_seq;

    always #5 clk = ~clk;

    chan_tx_sched #(.NCH(NCH), .DW(DW), .LW(LW), .IFG_CYC(IFG)) dut (
        .fifo_clk  (clk),
        .rst       (rst),
        .en        (en),
        .ch_mask   (ch_mask),
        .ch_req    (ch_req),
        .ch_len    (ch_len),
        .ch_data   (ch_data),
        .ch_rd     (ch_rd),
        .ch_grant  (ch_grant),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_sop    (tx_sop),
        .tx_eop    (tx_eop),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .frame_seq (frame_seq)
    );

    int checks   = 0;
    int failures = 0;

    logic [63:0] fifo   [NCH][$];
    int          bursts [NCH][$];
    beat_t       obs[$];

    int cyc            = 0;
    int viol           = 0;
    int rd_cnt         = 0;
    int last_eop_cyc   = -1;
    int min_gap        = 1000;
    int first_beat_cyc = -1;
    int m_ptr          = NCH - 1;
    int m_seq          = 0;

    logic        prev_stall = 1'b0;
    logic        prev_rst   = 1'b0;
    logic        prev_sop   = 1'b0;
    logic        prev_eop   = 1'b0;
    logic [63:0] prev_data  = '0;
    logic        pat [8]    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    task automatic refresh();
        for (int i = 0; i < NCH; i++) begin
            int len;
            len = (bursts[i].size() > 0) ? bursts[i][0] : 0;
            ch_len[i*LW +: LW]  = len[LW-1:0];
            ch_data[i*DW +: DW] = (fifo[i].size() > 0) ? fifo[i][0] : 64'h0;
            ch_req[i]           = (bursts[i].size() > 0) && (fifo[i].size() >= len);
        end
    endtask

    task automatic load(input int ch, input int len, input logic [63:0] base, input bit rnd);
        for (int w = 0; w < len; w++)
            fifo[ch].push_back(rnd ? {$urandom, $urandom} : base + 64'(w));
        bursts[ch].push_back(len);
        refresh();
    endtask

    task automatic flush();
        for (int i = 0; i < NCH; i++) begin
            fifo[i].delete();
            bursts[i].delete();
        end
        refresh();
    endtask

    // One clock: sample at negedge, then model the FIFOs popping just after posedge.
    task automatic tick();
        logic [15:0] rd_s;
        int          eop_g;
        beat_t       b;
        eop_g = -1;
        @(negedge clk);
        rd_s = ch_rd;
        if (!rst) begin
            if (tx_valid && tx_ready) begin
                b.data = tx_data; b.sop = tx_sop; b.eop = tx_eop; b.grant = ch_grant; b.cyc = cyc;
                obs.push_back(b);
                if (tx_sop && last_eop_cyc >= 0 && (cyc - last_eop_cyc) < min_gap)
                    min_gap = cyc - last_eop_cyc;
                if (tx_eop) begin
                    last_eop_cyc = cyc;
                    for (int i = 0; i < NCH; i++) if (ch_grant[i]) eop_g = i;
                end
            end
            if (rd_s != 0) begin
                rd_cnt++;
                if (!(tx_valid && tx_ready) || rd_s != ch_grant || $countones(rd_s) != 1) viol++;
            end
            if (prev_stall && !prev_rst &&
                (!tx_valid || tx_data !== prev_data || tx_sop !== prev_sop || tx_eop !== prev_eop))
                viol++;
            if (!busy && (tx_valid || ch_grant != 0)) viol++;
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_sop   = tx_sop;
        prev_eop   = tx_eop;
        prev_rst   = rst;
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < NCH; i++) begin
            if (rd_s[i]) begin
                if (fifo[i].size() > 0) void'(fifo[i].pop_front());
                else viol++;
            end
        end
        if (eop_g >= 0 && bursts[eop_g].size() > 0) void'(bursts[eop_g].pop_front());
        refresh();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        m_ptr = NCH - 1;
        m_seq = 0;
    endtask

    // Predict the whole frame stream from the queued bursts, then run the DUT and compare.
    task automatic run_expect(input int mode, input string name);
        beat_t expq[$];
        beat_t b, o;
        int    blen [NCH][$];
        int    pos  [NCH];
        int    nframes, idx, budget, viol0;
        nframes = 0;
        for (int i = 0; i < NCH; i++) begin
            blen[i] = bursts[i];
            pos[i]  = 0;
        end
        while (1) begin
            int w, len;
            w = -1;
            for (int k = 1; k <= NCH; k++) begin
                int i;
                i = (m_ptr + k) % NCH;
                if (w < 0 && ch_mask[i] && blen[i].size() > 0) w = i;
            end
            if (w < 0) break;
            len    = blen[w].pop_front();
            b.data = (64'hA5 << 56) | (64'(w) << 48) | (64'(len) << 40) | (64'(m_seq) << 24);
            b.sop  = 1'b1;
            b.eop  = (len == 0);
            b.grant = 16'(1) << w;
            b.cyc  = 0;
            expq.push_back(b);
            for (int j = 0; j < len; j++) begin
                b.data = fifo[w][pos[w] + j];
                b.sop  = 1'b0;
                b.eop  = (j == len - 1);
                expq.push_back(b);
            end
            pos[w] += len;
            m_ptr   = w;
            m_seq   = (m_seq + 1) & 16'hFFFF;
            nframes++;
        end

        first_beat_cyc = -1;
        min_gap        = 1000;
        last_eop_cyc   = -1;
        viol0          = viol;
        idx            = 0;
        budget         = 30 * expq.size() + 100;
        for (int t = 0; t < budget && idx < expq.size(); t++) begin
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (t < 8) ? pat[t] : 1'b1;
                default: tx_ready = ($urandom_range(0, 9) < 7);
            endcase
            tick();
            while (obs.size() > 0) begin
                o = obs.pop_front();
                if (first_beat_cyc < 0) first_beat_cyc = o.cyc;
                checks++;
                if (idx >= expq.size()) begin
                    failures++;
                    $display("FAIL %s extra beat data=%h sop=%b eop=%b", name, o.data, o.sop, o.eop);
                end else if ({o.data, o.sop, o.eop, o.grant} !==
                             {expq[idx].data, expq[idx].sop, expq[idx].eop, expq[idx].grant}) begin
                    failures++;
                    $display("FAIL %s beat%0d got data=%h sop=%b eop=%b grant=%h want data=%h sop=%b eop=%b grant=%h",
                             name, idx, o.data, o.sop, o.eop, o.grant,
                             expq[idx].data, expq[idx].sop, expq[idx].eop, expq[idx].grant);
                end
                idx++;
            end
        end
        checks++;
        if (idx < expq.size()) begin
            failures++;
            $display("FAIL %s timeout got %0d beats want %0d", name, idx, expq.size());
        end
        tx_ready = 1'b1;
        repeat (IFG + 8) tick();
        checks++;
        if (obs.size() != 0) begin
            failures++;
            $display("FAIL %s trailing beats got %0d want 0", name, obs.size());
        end
        obs.delete();
        checks++;
        if (viol != viol0) begin
            failures++;
            $display("FAIL %s protocol violations got %0d want 0", name, viol - viol0);
        end
        checks++;
        if (frame_seq !== 16'(m_seq)) begin
            failures++;
            $display("FAIL %s frame_seq got %0d want %0d", name, frame_seq, m_seq);
        end
        if (nframes > 1) begin
            checks++;
            if (min_gap < IFG + 1) begin
                failures++;
                $display("FAIL %s eop-to-header spacing got %0d want >= %0d", name, min_gap, IFG + 1);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; tx_ready = 1'b0;
        repeat (3) tick();
        checks++; if ({tx_valid, tx_sop, tx_eop} !== 3'b000) begin failures++; $display("FAIL reset valid/sop/eop got %b want 000", {tx_valid, tx_sop, tx_eop}); end
        checks++; if (tx_data !== 64'h0) begin failures++; $display("FAIL reset tx_data got %h want 0", tx_data); end
        checks++; if (ch_rd !== 16'h0) begin failures++; $display("FAIL reset ch_rd got %h want 0", ch_rd); end
        checks++; if (ch_grant !== 16'h0) begin failures++; $display("FAIL reset ch_grant got %h want 0", ch_grant); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset busy got %b want 0", busy); end
        checks++; if (frame_seq !== 16'h0) begin failures++; $display("FAIL reset frame_seq got %h want 0", frame_seq); end
        rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset idle busy got %b want 0", busy); end
    endtask

    task automatic test_single();
        int lc, r0;
        en = 1'b1;
        load(0, 4, 64'h10, 1'b0);
        lc = cyc;
        r0 = rd_cnt;
        run_expect(0, "single");
        checks++;
        if (first_beat_cyc != lc + 1) begin
            failures++;
            $display("FAIL single latency got cycle %0d want %0d", first_beat_cyc, lc + 1);
        end
        checks++;
        if (rd_cnt - r0 != 4) begin failures++; $display("FAIL single ch_rd pulses got %0d want 4", rd_cnt - r0); end
    endtask

    task automatic test_round_robin();
        int r0;
        do_reset();
        for (int i = 0; i < NCH; i++) load(i, 1, 64'h0, 1'b1);
        load(0, 1, 64'h0, 1'b1);
        r0 = rd_cnt;
        run_expect(0, "round_robin");
        checks++;
        if (rd_cnt - r0 != 17) begin failures++; $display("FAIL round_robin ch_rd pulses got %0d want 17", rd_cnt - r0); end
    endtask

    task automatic test_backpressure();
        int r0;
        load(5, 3, 64'h0, 1'b1);
        r0 = rd_cnt;
        run_expect(1, "backpressure");
        checks++;
        if (rd_cnt - r0 != 3) begin failures++; $display("FAIL backpressure ch_rd pulses got %0d want 3", rd_cnt - r0); end
    endtask

    task automatic test_len0_mask();
        int r0;
        en = 1'b0;
        load(9, 0, 64'h0, 1'b0);
        repeat (20) tick();
        checks++;
        if (obs.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL en_low got beats=%0d busy=%b want 0/0", obs.size(), busy);
        end
        en = 1'b1;
        r0 = rd_cnt;
        run_expect(0, "len0");
        checks++;
        if (rd_cnt != r0) begin failures++; $display("FAIL len0 ch_rd pulses got %0d want 0", rd_cnt - r0); end
        ch_mask[9] = 1'b0;
        load(9, 0, 64'h0, 1'b0);
        run_expect(0, "masked");
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL masked busy got %b want 0", busy); end
        flush();
        ch_mask = '1;
    endtask

    task automatic test_reset_mid();
        tx_ready = 1'b1;
        load(3, 8, 64'h0, 1'b1);
        for (int t = 0; t < 50 && obs.size() < 2; t++) tick();
        checks++;
        if (obs.size() < 2) begin failures++; $display("FAIL reset_mid frame start got %0d beats want 2", obs.size()); end
        rst = 1'b1;
        tick();
        checks++;
        if ({tx_valid, tx_sop, tx_eop, ch_rd, ch_grant, tx_data} !== '0) begin
            failures++;
            $display("FAIL reset_mid outputs got valid=%b rd=%h grant=%h data=%h want all 0", tx_valid, ch_rd, ch_grant, tx_data);
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_mid busy got %b want 0", busy); end
        checks++; if (frame_seq !== 16'h0) begin failures++; $display("FAIL reset_mid frame_seq got %h want 0", frame_seq); end
        flush();
        obs.delete();
        rst = 1'b0;
        m_ptr = NCH - 1;
        m_seq = 0;
        load(7, 1, 64'h0, 1'b1);
        load(0, 2, 64'h0, 1'b1);
        run_expect(0, "after_reset");
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            ch_mask = 16'($urandom) | 16'h0101;
            for (int n = 0; n < 12; n++) load($urandom_range(0, NCH - 1), $urandom_range(0, 5), 64'h0, 1'b1);
            run_expect(2, "random");
            flush();
            ch_mask = '1;
        end
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        tx_ready = 1'b0;
        ch_mask  = '1;
        ch_req   = '0;
        ch_len   = '0;
        ch_data  = '0;
        refresh();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_len0_mask();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
